// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver, transmitter and FIFO.
package uart_pkg;

   localparam int unsigned DATA_BITS    = 8;
   localparam int unsigned MIN_BAUD_DIV = 4;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO with an extra pointer bit to tell full from empty.
module uart_fifo #(
   parameter int unsigned Depth = 8,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam logic [AddrW:0] PtrOne = 1;

   logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
   end

   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: line synchronizer, bit-timing FSM and receive FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [15:0]          baud_div_i,
   input  logic                 rx_en_i,
   input  logic                 rx_bit_i,
   input  logic                 rx_re_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 frame_err_o,
   output logic                 overrun_o
);

   localparam int unsigned BitCntW = $clog2(DATA_BITS);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_BITS - 1);

   uart_state_e          state_q;
   logic [1:0]           sync_q;
   logic                 line;
   logic [15:0]          cnt_q, div_q, div_clamped, half_div;
   logic [BitCntW-1:0]   bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 tick, stop_good, push;
   logic                 frame_err_q, overrun_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= 2'b11;
      else         sync_q <= {sync_q[0], rx_bit_i};
   end
   assign line = sync_q[1];

   assign div_clamped = (baud_div_i < 16'(MIN_BAUD_DIV)) ? 16'(MIN_BAUD_DIV) : baud_div_i;
   assign half_div    = {1'b0, div_q[15:1]};

   always_comb begin
      tick = 1'b0;
      unique case (state_q)
         StStart:        tick = (cnt_q == half_div - 16'd1);
         StData, StStop: tick = (cnt_q == div_q - 16'd1);
         default:        tick = 1'b0;
      endcase
   end

   assign stop_good = rx_en_i && (state_q == StStop) && tick && line;
   assign push      = stop_good && (!full_o || rx_re_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         div_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         if (!rx_en_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (!line) begin
                     state_q <= StStart;
                     div_q   <= div_clamped;
                     cnt_q   <= '0;
                  end
               end
               StStart: begin
                  if (tick) begin
                     cnt_q     <= '0;
                     bit_cnt_q <= '0;
                     // A high line at mid-start-bit was a glitch, not a frame.
                     state_q   <= line ? StIdle : StData;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               StData: begin
                  if (tick) begin
                     cnt_q     <= '0;
                     shift_q   <= {line, shift_q[DATA_BITS-1:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == LastBit) state_q <= StStop;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               StStop: begin
                  if (tick) begin
                     cnt_q   <= '0;
                     state_q <= StIdle;
                     if (!line)                     frame_err_q <= 1'b1;
                     else if (full_o && !rx_re_i)   overrun_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 16'd1;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

   uart_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (DATA_BITS)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (shift_q),
      .pop_i   (rx_re_i),
      .data_o  (dout_o),
      .empty_o (empty_o),
      .full_o  (full_o)
   );

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 FIFO_DEPTH, 8, receive FIFO entries; SHALL be a power of two, at least 2.
REQ-002 clk_i  input  1  single clock for all logic.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 baud_div_i  input  16  clk_i cycles per bit.
REQ-005 rx_en_i  input  1  receiver enable.
REQ-006 rx_bit_i  input  1  serial line, asynchronous to clk_i, idle high.
REQ-007 rx_re_i  input  1  read strobe; pops the FIFO head.
REQ-008 dout_o  output  8  FIFO head byte, first-word-fall-through.
REQ-009 empty_o  output  1  FIFO empty.
REQ-010 full_o  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 frame_err_o  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-012 overrun_o  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 rx_bit_i SHALL pass through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-016 IDLE -> START SHALL occur when rx_en_i=1 and the synchronized line is 0.
- On this transition baud_div_i is latched.
- Latched values below 4 are clamped to 4.
REQ-017 START SHALL wait floor(div/2) cycles, then sample the line.
- Sample 0: go to DATA.
- Sample 1: false start; return to IDLE with no flags.
REQ-018 DATA SHALL sample every div cycles, 8 times, shifting bits in LSB first, then go to STOP.
REQ-019 STOP SHALL sample after div cycles, then return to IDLE on the next cycle.
- Return happens at mid-stop-bit, so back-to-back frames are received.
REQ-020 Stop sample 1 and FIFO not full: the byte SHALL be pushed.
- empty_o deasserts on the next cycle.
REQ-021 Stop sample 1 and FIFO full, with no pop in that cycle: the byte SHALL be dropped and overrun_o pulsed.
REQ-022 Stop sample 0: the byte SHALL be discarded and frame_err_o pulsed.
- Push and overrun are both suppressed.
REQ-023 rx_en_i=0 in any state SHALL force IDLE on the next cycle.
- The partial frame is discarded.
- FIFO contents are retained.
REQ-024 rx_re_i while empty_o=1 SHALL be ignored.
REQ-025 A pop while not empty SHALL advance the head on the next cycle.
REQ-026 Simultaneous push and pop SHALL both succeed, including when full; occupancy is unchanged.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH.
- Full/empty are distinguished by an extra pointer bit or an occupancy counter.
REQ-028 dout_o SHALL equal the head entry when empty_o=0; its value when empty is 8'h00.
REQ-029 A baud_div_i change mid-frame SHALL not affect the frame in progress.

Reset
REQ-030 While rst_ni=0, with no clock required:
- FSM = IDLE.
- Synchronizer = 1.
- Counters and shift register = 0.
- FIFO pointers = 0.
- empty_o=1, full_o=0, dout_o=8'h00, frame_err_o=0, overrun_o=0.
REQ-031 Reset mid-frame SHALL discard the frame and all FIFO contents.
REQ-032 Reset deassertion is synchronized externally; the first frame is received normally after release.

Structure
REQ-033 A shared package uart_pkg SHALL hold:
- the FSM state enum, shared with the transmitter;
- constants DATA_BITS=8 and MIN_BAUD_DIV=4.
REQ-034 The FIFO SHALL be a sub-module uart_fifo, parameterized by depth and width, reusable by the transmitter.
REQ-035 The RX FSM, bit counter and baud counter SHALL live in uart_rx.

Verification
REQ-036 baud_div_i=16, frame 0xA5 -> empty_o falls 155+/-1 cycles after the start edge, dout_o=8'hA5, no flags.
REQ-037 baud_div_i=16, 5-cycle low glitch on an idle line -> no push and no flags; FSM back in IDLE within 12 cycles.
REQ-038 baud_div_i=16, frame 0x3C with stop bit 0 -> frame_err_o pulses once and empty_o stays 1.
REQ-039 FIFO_DEPTH=8, 9 frames 0x00..0x08, no reads:
- full_o=1 after the 8th frame;
- overrun_o pulses once on the 9th;
- reads return 0x00..0x07.
REQ-040 FIFO full with rx_re_i=1 in the same cycle as the stop sample -> no overrun; the next read order continues correctly.
REQ-041 rst_ni pulsed low during DATA bit 4 with 2 bytes queued -> empty_o=1 immediately; the next 0x81 frame is received correctly.
